// File: rtl/gldp_frc.sv
// Frame-rate-control dither for a gray-level panel driver: each channel's level
// becomes a 1-bit drive whose duty over P consecutive frames equals L/P.
module gldp_frc #(
    parameter int IN_BITS  = 5,
    parameter int CHANNELS = 3,
    parameter int INV_OFS  = 15,
    parameter int CH_OFS   = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flm,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [CHANNELS*IN_BITS-1:0]  raw_in,
    input  logic                         inv,
    output logic                         out_valid,
    output logic [CHANNELS-1:0]          dither_out,
    output logic [IN_BITS-1:0]           phase
);

    localparam int QW = IN_BITS + 4;
    localparam logic [QW-1:0]      P_Q   = QW'((1 << IN_BITS) - 1);
    localparam logic [IN_BITS-1:0] P_L   = IN_BITS'((1 << IN_BITS) - 1);
    localparam logic [IN_BITS-1:0] P_M1  = IN_BITS'((1 << IN_BITS) - 2);
    localparam logic [IN_BITS-1:0] ONE_L = IN_BITS'(1);
    localparam logic [QW-1:0]      INV_Q = QW'(INV_OFS);

    // Sum is below 9*P, so restoring subtraction of 8P, 4P, 2P, P leaves x mod P.
    function automatic logic [IN_BITS-1:0] mod_p(input logic [QW-1:0] x);
        logic [QW-1:0] t;
        t = x;
        for (int k = 3; k >= 0; k--) begin
            t = (t >= (P_Q << k)) ? (t - (P_Q << k)) : t;
        end
        return t[IN_BITS-1:0];
    endfunction

    // 2^IN_BITS == 1 mod P, so folding the product's halves with end-around carry reduces it.
    function automatic logic [IN_BITS-1:0] mulmod_p(input logic [IN_BITS-1:0] q,
                                                    input logic [IN_BITS-1:0] l);
        logic [2*IN_BITS-1:0] prod;
        logic [IN_BITS:0]     f1;
        logic [IN_BITS-1:0]   f2;
        prod = {{IN_BITS{1'b0}}, q} * {{IN_BITS{1'b0}}, l};
        f1   = {1'b0, prod[IN_BITS-1:0]} + {1'b0, prod[2*IN_BITS-1:IN_BITS]};
        f2   = f1[IN_BITS-1:0] + {{(IN_BITS-1){1'b0}}, f1[IN_BITS]};
        return (f2 == P_L) ? {IN_BITS{1'b0}} : f2;
    endfunction

    logic                        flm_d_r;
    logic                        frame_edge_s;
    logic [IN_BITS-1:0]          phase_r;
    logic                        v1_r;
    logic                        en1_r;
    logic [CHANNELS*IN_BITS-1:0] lvl_r;
    logic [CHANNELS*IN_BITS-1:0] q1_r;
    logic [CHANNELS*IN_BITS-1:0] q_s;
    logic [CHANNELS-1:0]         dith_s;
    logic                        out_valid_r;
    logic [CHANNELS-1:0]         dither_r;

    assign frame_edge_s = flm & ~flm_d_r;

    // Frame-edge detector and frame-phase counter; flm_d resets high so a held flm is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flm_d_r <= 1'b1;
            phase_r <= {IN_BITS{1'b0}};
        end else begin
            flm_d_r <= flm;
            if (frame_edge_s) begin
                phase_r <= (phase_r == P_M1) ? {IN_BITS{1'b0}} : (phase_r + ONE_L);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [QW-1:0] CH_Q = QW'(c * CH_OFS);
        logic [IN_BITS-1:0] lvl_s;
        logic [IN_BITS-1:0] r_s;

        assign q_s[c*IN_BITS +: IN_BITS] =
            mod_p({4'b0000, phase_r} + (inv ? INV_Q : {QW{1'b0}}) + CH_Q);

        assign lvl_s = lvl_r[c*IN_BITS +: IN_BITS];
        assign r_s   = mulmod_p(q1_r[c*IN_BITS +: IN_BITS], lvl_s);

        // Dither decision, or plain MSB when FRC is bypassed.
        always_comb begin
            dith_s[c] = 1'b0;
            if (en1_r) begin
                dith_s[c] = (({1'b0, r_s} + {1'b0, lvl_s}) >= {1'b0, P_L});
            end else begin
                dith_s[c] = lvl_s[IN_BITS-1];
            end
        end
    end

    // Stage 1: capture levels, mode and effective phase using the pre-increment phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r  <= 1'b0;
            en1_r <= 1'b0;
            lvl_r <= {(CHANNELS*IN_BITS){1'b0}};
            q1_r  <= {(CHANNELS*IN_BITS){1'b0}};
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                en1_r <= en;
                lvl_r <= raw_in;
                q1_r  <= q_s;
            end
        end
    end

    // Stage 2: registered outputs; drive value holds across gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            dither_r    <= {CHANNELS{1'b0}};
        end else begin
            out_valid_r <= v1_r;
            if (v1_r) begin
                dither_r <= dith_s;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign dither_out = dither_r;
    assign phase      = phase_r;

endmodule

// File: tb/tb_gldp_frc.sv
// Directed bench for gldp_frc at defaults (IN_BITS=5, CHANNELS=3, P=31) with
// hand-computed expected drive values.
module tb_gldp_frc;

    logic        clk = 1'b0;
    logic        rst;
    logic        flm;
    logic        en;
    logic        in_valid;
    logic [14:0] raw_in;
    logic        inv;
    logic        out_valid;
    logic [2:0]  dither_out;
    logic [4:0]  phase;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] d;
    logic [2:0] e;
    int ones16 [2][3];
    int hp [2][3] = '{'{30, 20, 10}, '{15, 5, 26}};

    logic        s_vld [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [14:0] s_lvl [6] = '{{5'd31, 5'd15, 5'd16}, {5'd0, 5'd31, 5'd0},
                               15'd0, {5'd16, 5'd0, 5'd0}, 15'd0, 15'd0};
    logic        s_en  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        x_ov  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  x_d   [6] = '{3'b000, 3'b101, 3'b010, 3'b010, 3'b100, 3'b100};

    always #5 clk = ~clk;

    gldp_frc dut (
        .clk        (clk),
        .rst        (rst),
        .flm        (flm),
        .en         (en),
        .in_valid   (in_valid),
        .raw_in     (raw_in),
        .inv        (inv),
        .out_valid  (out_valid),
        .dither_out (dither_out),
        .phase      (phase)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] lv(input logic [4:0] c0, input logic [4:0] c1,
                                       input logic [4:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic beat(input logic [14:0] lvl, input logic i, input logic m,
                        output logic [2:0] dout);
        raw_in   = lvl;
        inv      = i;
        en       = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_val("beat_out_valid", out_valid, 1);
        dout = dither_out;
    endtask

    task automatic next_frame();
        flm = 1'b0;
        tick();
        flm = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; flm = 1'b1; en = 1'b1; in_valid = 1'b0; inv = 1'b0; raw_in = 15'd0;
        for (int i = 0; i < 2; i++) for (int c = 0; c < 3; c++) ones16[i][c] = 0;
        tick();
        tick();
        check_val("rst_phase", phase, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_dither", dither_out, 0);
        rst = 1'b0;
        repeat (3) tick();
        check_val("flm_held_no_edge", phase, 0);

        // Full FRC period: constant levels, single-level phase positions, duty counts.
        for (int p = 0; p < 31; p++) begin
            check_val("phase", phase, p);
            for (int i = 0; i < 2; i++) begin
                beat(lv(5'd0, 5'd0, 5'd0), i[0], 1'b1, d);
                check_val("lvl0", d, 3'b000);
                beat(lv(5'd31, 5'd31, 5'd31), i[0], 1'b1, d);
                check_val("lvl31", d, 3'b111);
                beat(lv(5'd1, 5'd1, 5'd1), i[0], 1'b1, d);
                for (int c = 0; c < 3; c++) e[c] = (p == hp[i][c]);
                check_val("lvl1", d, e);
                beat(lv(5'd16, 5'd16, 5'd16), i[0], 1'b1, d);
                for (int c = 0; c < 3; c++) ones16[i][c] += int'(d[c]);
            end
            next_frame();
        end
        check_val("phase_wrap", phase, 0);
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++)
                check_val("lvl16_count", ones16[i][c], 16);

        // Bypass: MSB of 16, 15, 31 on both inv values and two phases.
        for (int f = 0; f < 2; f++) begin
            beat(lv(5'd16, 5'd15, 5'd31), 1'b0, 1'b0, d);
            check_val("bypass_inv0", d, 3'b101);
            beat(lv(5'd16, 5'd15, 5'd31), 1'b1, 1'b0, d);
            check_val("bypass_inv1", d, 3'b101);
            if (f == 0) next_frame();
        end

        // Streaming with a gap and per-beat en changes (phase 1).
        for (int k = 0; k < 6; k++) begin
            in_valid = s_vld[k];
            raw_in   = s_lvl[k];
            en       = s_en[k];
            inv      = 1'b0;
            tick();
            check_val("stream_out_valid", out_valid, x_ov[k]);
            if (k > 0) check_val("stream_dither", dither_out, x_d[k]);
        end
        en = 1'b1;

        // Frame edge coincident with a beat at phase 30.
        repeat (29) next_frame();
        check_val("phase_30", phase, 30);
        flm = 1'b0;
        tick();
        flm = 1'b1; raw_in = lv(5'd1, 5'd0, 5'd0); inv = 1'b0; en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("edge_phase_next", phase, 0);
        check_val("edge_out_valid_early", out_valid, 0);
        tick();
        check_val("edge_out_valid", out_valid, 1);
        check_val("edge_old_phase", dither_out, 3'b001);

        // Reset with beats in flight and flm held high.
        next_frame();
        check_val("pre_rst_phase", phase, 1);
        raw_in = lv(5'd31, 5'd31, 5'd31); in_valid = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", out_valid, 0);
        check_val("mid_rst_phase", phase, 0);
        check_val("mid_rst_dither", dither_out, 0);
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("post_rst_out_valid", out_valid, 0);
            check_val("post_rst_phase", phase, 0);
        end
        next_frame();
        check_val("post_rst_first_edge", phase, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gldp_frc.md
GLDP_FRC -- requirements
Module: gldp_frc

Interface
REQ-001 SHALL provide parameter IN_BITS, default 5, gray-level input width per channel, legal range 2..8.
REQ-002 SHALL provide parameter CHANNELS, default 3, number of independent colour channels per pixel, legal range 1..8.
REQ-003 SHALL provide parameter INV_OFS, default 15, frame-phase offset applied when inv=1.
REQ-004 SHALL provide parameter CH_OFS, default 10, frame-phase offset step per channel index.
REQ-005 SHALL derive local constant P = 2^IN_BITS - 1 as the FRC period in frames; INV_OFS and CH_OFS SHALL be < P.
REQ-006 SHALL have one clock and an asynchronous, active-high reset; ports are clk and rst.
REQ-007 Ports:
- clk  in  1  pixel clock
- rst  in  1  async active-high reset
- flm  in  1  first-line marker, synchronous to clk, level signal
- en  in  1  1 = FRC dithering, 0 = MSB truncation bypass
- in_valid  in  1  raw_in/inv qualify
- raw_in  in  CHANNELS*IN_BITS  gray levels; channel c at bits [c*IN_BITS +: IN_BITS]
- inv  in  1  alternate-phase select (line/pixel parity)
- out_valid  out  1  dither_out qualify
- dither_out  out  CHANNELS  1-bit drive value per channel
- phase  out  IN_BITS  current frame phase, 0..P-1

Function
REQ-008 SHALL register flm into flm_d each clk; a frame edge is flm=1 and flm_d=0.
REQ-009 On a frame edge, phase SHALL increment by 1, wrapping P-1 -> 0; otherwise it SHALL hold.
REQ-010 For channel c, the effective phase SHALL be q = (phase + (inv ? INV_OFS : 0) + c*CH_OFS) mod P, computed without overflow at IN_BITS+4 bits.
REQ-011 With level L in channel c, SHALL compute r = (q*L) mod P, using end-around-carry folding of the 2*IN_BITS product; a fold result equal to P SHALL map to 0.
REQ-012 With en=1, dither_out[c] SHALL be 1 iff r + L >= P; thus L=0 is always 0, L=P is always 1, and exactly L ones occur over any P consecutive phases.
REQ-013 With en=0, dither_out[c] SHALL equal raw_in bit IN_BITS-1 of channel c; phase SHALL keep advancing.
REQ-014 Pipeline SHALL be 2 stages: stage 1 registers levels, inv, en and per-channel q; stage 2 registers dither_out; out_valid SHALL follow in_valid exactly 2 clk later.
REQ-015 Sampled phase SHALL be the value held before any same-cycle increment; a pixel with in_valid coincident with a frame edge SHALL use the old phase.
REQ-016 SHALL have no backpressure; every in_valid beat SHALL produce one out_valid beat, and gaps SHALL propagate.
REQ-017 While out_valid=0, dither_out SHALL hold its previous value.
REQ-018 en and inv SHALL be sampled per beat together with raw_in; a mid-frame change SHALL affect only subsequent beats.

Reset
REQ-019 rst=1 SHALL immediately set phase=0, flm_d=1, both pipeline valid bits=0, out_valid=0, dither_out=0.
REQ-020 flm held high through reset release SHALL NOT generate a frame edge; the first edge requires flm to go low and then high.
REQ-021 rst asserted mid-stream SHALL discard in-flight beats; no out_valid SHALL appear for beats accepted before reset.

Verification (IN_BITS=5, CHANNELS=3, defaults, P=31)
REQ-022 Levels 0 and 31 on all channels, en=1, 31 frames, inv in {0,1} -> dither_out always 000 and 111 respectively.
REQ-023 Level 1, channel 0, inv=0 -> 1 only at phase 30; inv=1 -> 1 only at phase 15; channel 1, inv=0 -> 1 only at phase 20.
REQ-024 Level 16 on every channel and every inv, sampled once per frame for 31 frames -> exactly 16 ones per channel.
REQ-025 Frame edge coincident with in_valid at phase 30 -> that beat uses phase 30, phase reads 0 the next cycle, out_valid rises 2 cycles after in_valid.
REQ-026 en=0 with raw_in channels 16, 15, 31 -> dither_out = 101 regardless of phase.
REQ-027 rst pulse with 2 beats in flight and flm=1 -> out_valid=0 and phase=0 immediately; no out_valid for those beats; phase stays 0 until a new low-to-high flm transition.
